// File: rtl/timer_set_ctrl_if.sv
// timer_set_ctrl_if: button/tick/digit-select inputs and display/state outputs of the mode controller
interface timer_set_ctrl_if;
    logic        i_btn_center;
    logic        i_btn_left;
    logic        i_btn_right;
    logic        i_btn_up;
    logic        i_btn_down;
    logic        i_tick_1hz;
    logic [3:0]  i_digit_select;
    logic        o_shift_left;
    logic        o_shift_right;
    logic [15:0] o_digits;
    logic [1:0]  o_state;
    logic        o_done;
    modport master (
        output i_btn_center, i_btn_left, i_btn_right, i_btn_up, i_btn_down, i_tick_1hz, i_digit_select,
        input  o_shift_left, o_shift_right, o_digits, o_state, o_done
    );
    modport slave (
        input  i_btn_center, i_btn_left, i_btn_right, i_btn_up, i_btn_down, i_tick_1hz, i_digit_select,
        output o_shift_left, o_shift_right, o_digits, o_state, o_done
    );
endinterface

// File: rtl/timer_set_ctrl.sv
// timer_set_ctrl: SET/RUN/PAUSE/DONE mode FSM owning the MM:SS BCD digits and digit-select shift strobes
module timer_set_ctrl #(
    parameter int MIN_TENS_MAX = 9
) (
    input logic             i_clk,
    input logic             i_rst,
    timer_set_ctrl_if.slave bus
);
    typedef enum logic [1:0] {SET = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    localparam logic [15:0] LIMITS = {4'(MIN_TENS_MAX), 4'd9, 4'd5, 4'd9};

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d, preset_q, preset_d, dec_t;
    logic        shl_q, shl_d, shr_q, shr_d;
    logic        c, l, r, u, dn, sel_ok;

    function automatic logic [3:0] wrap(input logic [3:0] v, input logic [3:0] m, input logic up);
        return up ? (v == m ? 4'd0 : v + 4'd1) : (v == 4'd0 ? m : v - 4'd1);
    endfunction

    // one-second BCD countdown; caller guarantees t is nonzero
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [15:0] n;
        n = t;
        if (t[3:0] != 4'd0) n[3:0] = t[3:0] - 4'd1;
        else begin
            n[3:0] = 4'd9;
            if (t[7:4] != 4'd0) n[7:4] = t[7:4] - 4'd1;
            else begin
                n[7:4] = 4'd5;
                if (t[11:8] != 4'd0) n[11:8] = t[11:8] - 4'd1;
                else begin
                    n[11:8]  = 4'd9;
                    n[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        c        = bus.i_btn_center;
        l        = bus.i_btn_left & ~c;
        r        = bus.i_btn_right & ~c & ~bus.i_btn_left;
        u        = bus.i_btn_up & ~(c | bus.i_btn_left | bus.i_btn_right);
        dn       = bus.i_btn_down & ~(c | bus.i_btn_left | bus.i_btn_right | bus.i_btn_up);
        sel_ok   = $onehot(bus.i_digit_select);
        dec_t    = dec_time(digits_q);
        state_d  = state_q;
        digits_d = digits_q;
        preset_d = preset_q;
        shl_d    = 1'b0;
        shr_d    = 1'b0;
        case (state_q)
            SET: begin
                shl_d = l;
                shr_d = r;
                if ((u | dn) && sel_ok)
                    for (int i = 0; i < 4; i++)
                        if (bus.i_digit_select[i]) digits_d[4*i+:4] = wrap(digits_q[4*i+:4], LIMITS[4*i+:4], u);
                if (c && digits_q != 16'h0000) begin
                    preset_d = digits_q;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.i_tick_1hz) digits_d = dec_t;
                state_d = (bus.i_tick_1hz && dec_t == 16'h0000) ? DONE : c ? PAUSE : RUN;
            end
            PAUSE: state_d = c ? RUN : (l | r) ? SET : PAUSE;
            DONE: begin
                if (c) begin
                    state_d  = SET;
                    digits_d = preset_q;
                end
            end
            default: state_d = SET;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= SET;
            digits_q <= 16'h0000;
            preset_q <= 16'h0000;
            shl_q    <= 1'b0;
            shr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            preset_q <= preset_d;
            shl_q    <= shl_d;
            shr_q    <= shr_d;
        end
    end

    assign bus.o_shift_left  = shl_q;
    assign bus.o_shift_right = shr_q;
    assign bus.o_digits      = digits_q;
    assign bus.o_state       = state_q;
    assign bus.o_done        = (state_q == DONE);
endmodule

// File: tb/tb_timer_set_ctrl.sv
// tb_timer_set_ctrl: scoreboard bench; a seconds-based model predicts each cycle's outputs
module tb_timer_set_ctrl;
    localparam logic [4:0] N = 5'b00000, C = 5'b10000, L = 5'b01000, R = 5'b00100, U = 5'b00010, D = 5'b00001;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    timer_set_ctrl_if bus();
    timer_set_ctrl #(.MIN_TENS_MAX(9)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    int          n_run = 0, n_fail = 0;
    logic [31:0] exp_q[$];
    int          ms = 0;
    int          md[4] = '{0, 0, 0, 0};
    int          mp[4] = '{0, 0, 0, 0};
    logic [3:0]  sel = 4'b0001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_run++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int lim(input int i);
        return (i == 1) ? 5 : 9;
    endfunction

    function automatic int secs();
        return (md[3] * 10 + md[2]) * 60 + md[1] * 10 + md[0];
    endfunction

    task automatic step(input string tag, input logic [4:0] b, input logic tk, input logic rs = 1'b0);
        logic eshl, eshr;
        int   s;
        logic [15:0] dg;
        {bus.i_btn_center, bus.i_btn_left, bus.i_btn_right, bus.i_btn_up, bus.i_btn_down} = b;
        bus.i_tick_1hz     = tk;
        bus.i_digit_select = sel;
        i_rst              = rs;
        eshl = 1'b0;
        eshr = 1'b0;
        s    = secs();
        if (rs) begin
            ms = 0;
            for (int i = 0; i < 4; i++) begin md[i] = 0; mp[i] = 0; end
        end else case (ms)
            0: begin
                if (b[4]) begin
                    if (s != 0) begin mp = md; ms = 1; end
                end else if (b[3]) eshl = 1'b1;
                else if (b[2]) eshr = 1'b1;
                else if ((b[1] || b[0]) && $onehot(sel))
                    for (int i = 0; i < 4; i++)
                        if (sel[i]) md[i] = b[1] ? (md[i] == lim(i) ? 0 : md[i] + 1) : (md[i] == 0 ? lim(i) : md[i] - 1);
            end
            1: begin
                if (tk) begin
                    s = s - 1;
                    md[0] = s % 10; md[1] = (s % 60) / 10; md[2] = (s / 60) % 10; md[3] = s / 600;
                end
                if (tk && s == 0) ms = 3;
                else if (b[4]) ms = 2;
            end
            2: if (b[4]) ms = 1; else if (b[3] || b[2]) ms = 0;
            3: if (b[4]) begin ms = 0; md = mp; end
            default: ms = 0;
        endcase
        dg = {md[3][3:0], md[2][3:0], md[1][3:0], md[0][3:0]};
        exp_q.push_back({11'd0, ms[1:0], ms == 3, eshl, eshr, dg});
        @(posedge i_clk);
        #1;
        check(tag, {11'd0, bus.o_state, bus.o_done, bus.o_shift_left, bus.o_shift_right, bus.o_digits}, exp_q.pop_front());
        if (bus.o_shift_left) sel = {sel[2:0], sel[3]};
        else if (bus.o_shift_right) sel = {sel[0], sel[3:1]};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        {bus.i_btn_center, bus.i_btn_left, bus.i_btn_right, bus.i_btn_up, bus.i_btn_down, bus.i_tick_1hz} = '0;
        bus.i_digit_select = sel;
        step("rst_drop", C | U, 1'b1, 1'b1);
        step("rst", N, 1'b0, 1'b1);
        repeat (3) step("edit_d0", U, 1'b0);
        step("shl1", L, 1'b0);
        repeat (7) step("edit_d1", U, 1'b0);
        step("shl2", L, 1'b0);
        repeat (2) step("edit_d2", U, 1'b0);
        check("plan_digits", {16'd0, bus.o_digits}, 32'h0213);
        step("shr", R, 1'b0);
        repeat (4) step("d1_to5", U, 1'b0);
        step("d1_wrap_up", U, 1'b0);
        step("d1_wrap_dn", D, 1'b0);
        repeat (2) step("to_d3", L, 1'b0);
        step("d3_wrap_dn", D, 1'b0);
        step("d3_wrap_up", U, 1'b0);
        sel = 4'b0011;
        step("sel_multi", U, 1'b0);
        sel = 4'b0000;
        step("sel_none", D, 1'b0);
        sel = 4'b1000;
        step("left_up", L | U, 1'b0);
        step("set_tick", N, 1'b1);
        step("rst", N, 1'b0, 1'b1);
        sel = 4'b0100;
        step("load_1m", U, 1'b0);
        step("start", C, 1'b0);
        repeat (60) step("run_tick", N, 1'b1);
        check("done_flag", {31'd0, bus.o_done}, 32'd1);
        step("done_hold", L | U, 1'b1);
        step("done_ack", C, 1'b0);
        step("rst", N, 1'b0, 1'b1);
        sel = 4'b0001;
        repeat (5) step("load_5s", U, 1'b0);
        step("start", C, 1'b0);
        step("tick_pause", C, 1'b1);
        repeat (3) step("pause_tick", N, 1'b1);
        step("resume", C, 1'b0);
        step("run_right", R, 1'b0);
        step("run_up", U, 1'b1);
        step("pause", C, 1'b0);
        step("pause_up", U, 1'b0);
        step("pause_left", L, 1'b0);
        sel = 4'b0001;
        repeat (2) step("to_1s", D, 1'b0);
        step("start", C, 1'b0);
        step("tick_done", C, 1'b1);
        step("done_ack", C, 1'b0);
        step("rst", N, 1'b0, 1'b1);
        step("zero_start", C, 1'b0);
        sel = 4'b1000; step("d3", U, 1'b0);
        sel = 4'b0100; repeat (2) step("d2", U, 1'b0);
        sel = 4'b0010; repeat (3) step("d1", U, 1'b0);
        sel = 4'b0001; repeat (4) step("d0", U, 1'b0);
        step("start", C, 1'b0);
        step("run", N, 1'b0);
        step("mid_rst", C | L, 1'b1, 1'b1);
        step("after_rst", N, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
